// File: rtl/frame_cfg_pkg.sv
// Shared constants and types for the frame configuration sequencer: opcodes,
// default sync word, header field positions and FSM state encoding.
package frame_cfg_pkg;

   localparam logic [7:0]  OP_WRITE  = 8'h01;
   localparam logic [7:0]  OP_END    = 8'h02;
   localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

   localparam int unsigned HDR_OP_MSB  = 31;
   localparam int unsigned HDR_OP_LSB  = 24;
   localparam int unsigned HDR_IDX_MSB = 23;
   localparam int unsigned HDR_IDX_LSB = 16;
   localparam int unsigned HDR_CNT_MSB = 15;
   localparam int unsigned HDR_CNT_LSB = 0;

   localparam int unsigned IdxW = HDR_IDX_MSB - HDR_IDX_LSB + 1;
   localparam int unsigned CntW = HDR_CNT_MSB - HDR_CNT_LSB + 1;

   typedef enum logic [2:0] {
      StIdle,
      StHeader,
      StData,
      StStrobe,
      StCheck,
      StErr
   } state_e;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Index-to-one-hot frame strobe decoder; all-zero when disabled or when the
// index lies outside the column.
module frame_strobe_decoder #(
   parameter int unsigned NumFrames = 20,
   parameter int unsigned IdxWidth  = 8
) (
   input  logic [IdxWidth-1:0]  idx_i,
   input  logic                 en_i,
   output logic [NumFrames-1:0] strobe_o
);

   always_comb begin
      strobe_o = '0;
      for (int unsigned i = 0; i < NumFrames; i++) begin
         if (en_i && (idx_i == IdxWidth'(i))) begin
            strobe_o[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/frame_config_sequencer.sv
// Bitstream-driven frame loader: sync, header decode, per-frame data + strobe.
// Optional FRAME_CHECKSUM_EN adds an XOR checksum word after each WRITE block.
module frame_config_sequencer
   import frame_cfg_pkg::*;
#(
   parameter int unsigned                FrameBitsPerRow = 32,
   parameter int unsigned                MaxFramesPerCol = 20,
   parameter logic [FrameBitsPerRow-1:0] SyncWord        = SYNC_WORD
) (
   input  logic                       UserCLK,
   input  logic                       reset,
   input  logic [FrameBitsPerRow-1:0] s_data,
   input  logic                       s_valid,
   output logic                       s_ready,
   output logic [FrameBitsPerRow-1:0] FrameData,
   output logic [MaxFramesPerCol-1:0] FrameStrobe,
   output logic                       busy,
   output logic                       done,
   output logic                       error
);

   state_e                     state_q, state_d;
   logic [FrameBitsPerRow-1:0] frame_data_q, frame_data_d;
   logic [IdxW-1:0]            index_q, index_d;
   logic [CntW-1:0]            remaining_q, remaining_d;
   logic                       done_q, done_d;
   logic                       error_q, error_d;

   logic                       accept;
   logic                       is_sync;
   logic [7:0]                 hdr_op;
   logic [IdxW-1:0]            hdr_start;
   logic [CntW-1:0]            hdr_cnt;
   logic [CntW:0]              hdr_end;

   assign s_ready   = (state_q != StStrobe);
   assign accept    = s_valid && s_ready;
   assign is_sync   = (s_data == SyncWord);
   assign hdr_op    = s_data[HDR_OP_MSB:HDR_OP_LSB];
   assign hdr_start = s_data[HDR_IDX_MSB:HDR_IDX_LSB];
   assign hdr_cnt   = s_data[HDR_CNT_MSB:HDR_CNT_LSB];
   // 17-bit sum so that a large count can never wrap back into range
   assign hdr_end   = (CntW+1)'(hdr_start) + (CntW+1)'(hdr_cnt);

`ifdef FRAME_CHECKSUM_EN
   logic [FrameBitsPerRow-1:0] acc_q, acc_d;

   always_comb begin
      acc_d = acc_q;
      if (accept && (state_q == StHeader)) begin
         acc_d = '0;
      end else if (accept && (state_q == StData)) begin
         acc_d = acc_q ^ s_data;
      end
   end

   always_ff @(posedge UserCLK) begin
      if (reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
`endif

   always_comb begin
      state_d      = state_q;
      frame_data_d = frame_data_q;
      index_d      = index_q;
      remaining_d  = remaining_q;
      done_d       = 1'b0;
      error_d      = error_q;
      case (state_q)
         StIdle: begin
            if (accept && is_sync) begin
               state_d = StHeader;
            end
         end
         StHeader: begin
            if (accept) begin
               if (hdr_op == OP_WRITE) begin
                  if (hdr_cnt == '0) begin
                     state_d = StHeader;
                  end else if (hdr_end <= (CntW+1)'(MaxFramesPerCol)) begin
                     index_d     = hdr_start;
                     remaining_d = hdr_cnt;
                     state_d     = StData;
                  end else begin
                     error_d = 1'b1;
                     state_d = StErr;
                  end
               end else if (hdr_op == OP_END) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  error_d = 1'b1;
                  state_d = StErr;
               end
            end
         end
         StData: begin
            if (accept) begin
               frame_data_d = s_data;
               state_d      = StStrobe;
            end
         end
         StStrobe: begin
            index_d     = index_q + IdxW'(1);
            remaining_d = remaining_q - CntW'(1);
            if (remaining_q == CntW'(1)) begin
`ifdef FRAME_CHECKSUM_EN
               state_d = StCheck;
`else
               state_d = StHeader;
`endif
            end else begin
               state_d = StData;
            end
         end
`ifdef FRAME_CHECKSUM_EN
         StCheck: begin
            if (accept) begin
               if (s_data == acc_q) begin
                  state_d = StHeader;
               end else begin
                  error_d = 1'b1;
                  state_d = StErr;
               end
            end
         end
`endif
         StErr: begin
            if (accept && is_sync) begin
               error_d = 1'b0;
               state_d = StHeader;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge UserCLK) begin
      if (reset) begin
         state_q      <= StIdle;
         frame_data_q <= '0;
         index_q      <= '0;
         remaining_q  <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_data_q <= frame_data_d;
         index_q      <= index_d;
         remaining_q  <= remaining_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   // Reset masks the strobe combinationally so an abort never writes a frame
   frame_strobe_decoder #(
      .NumFrames (MaxFramesPerCol),
      .IdxWidth  (IdxW)
   ) u_strobe_dec (
      .idx_i    (index_q),
      .en_i     ((state_q == StStrobe) && !reset),
      .strobe_o (FrameStrobe)
   );

   assign FrameData = frame_data_q;
   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Directed bench for frame_config_sequencer with a strobe scoreboard.
// Define FRAME_CHECKSUM_EN to exercise the checksum word as well.
module tb_frame_config_sequencer;

   logic        UserCLK = 1'b0;
   logic        reset;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] FrameData;
   logic [19:0] FrameStrobe;
   logic        busy;
   logic        done;
   logic        error;

   typedef struct {
      int          idx;
      logic [31:0] data;
   } sb_item_t;

   sb_item_t sb[$];
   int       strobe_cyc[$];
   sb_item_t mon_e;
   int       cyc = 0;
   int       passed = 0;
   int       total = 0;

   frame_config_sequencer dut (
      .UserCLK     (UserCLK),
      .reset       (reset),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .FrameData   (FrameData),
      .FrameStrobe (FrameStrobe),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   always #5 UserCLK = ~UserCLK;
   always @(posedge UserCLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Holds the word until accepted; inputs change 1 time unit after the edge.
   task automatic send_word(input logic [31:0] w);
      bit got = 1'b0;
      int n = 0;
      s_data  = w;
      s_valid = 1'b1;
      while (!got) begin
         @(negedge UserCLK);
         got = s_ready;
         @(posedge UserCLK);
         #1;
         n++;
         if (!got && n > 50) begin
            check("accept_timeout", 32'(got), 32'd1);
            break;
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic send_frame(input int idx, input logic [31:0] w);
      sb_item_t it;
      it.idx  = idx;
      it.data = w;
      sb.push_back(it);
      send_word(w);
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) begin
         @(posedge UserCLK);
         #1;
      end
   endtask

   always @(negedge UserCLK) begin
      if (FrameStrobe !== '0) begin
         strobe_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            check("unexpected_strobe", 32'(FrameStrobe), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("strobe_onehot", 32'(FrameStrobe), 32'd1 << mon_e.idx);
            check("strobe_data", FrameData, mon_e.data);
            check("strobe_ready_low", 32'(s_ready), 32'd0);
         end
      end
   end

   initial begin
      reset   = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      repeat (3) @(posedge UserCLK);
      #1 reset = 1'b0;
      @(negedge UserCLK);
      check("rst_ready", 32'(s_ready), 32'd1);
      check("rst_data", FrameData, 32'd0);
      check("rst_strobe", 32'(FrameStrobe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);

      // Non-sync words in IDLE are discarded
      send_word(32'h0100_0001);
      check("idle_discard_busy", 32'(busy), 32'd0);

      // Basic three-frame write at full throughput
      send_word(32'hFAB0_FAB1);
      check("sync_busy", 32'(busy), 32'd1);
      send_word(32'h0100_0003);
      strobe_cyc.delete();
      send_frame(0, 32'hAAAA_0001);
      send_frame(1, 32'hAAAA_0002);
      send_frame(2, 32'hAAAA_0003);
      idle(2);
      check("basic_drained", 32'(sb.size()), 32'd0);
      check("basic_strobe_cnt", 32'(strobe_cyc.size()), 32'd3);
      if (strobe_cyc.size() == 3) begin
         check("basic_gap01", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd2);
         check("basic_gap12", 32'(strobe_cyc[2] - strobe_cyc[1]), 32'd2);
      end

      // Last frame of the column
      send_word(32'h0113_0001);
      send_frame(19, 32'h1234_5678);
      idle(2);
      check("bound_drained", 32'(sb.size()), 32'd0);
      check("bound_ok_err", 32'(error), 32'd0);

      // One past the end of the column
      send_word(32'h0113_0002);
      check("overrun_err", 32'(error), 32'd1);
      check("overrun_busy", 32'(busy), 32'd1);
      send_word(32'hAAAA_0000);
      idle(2);
      check("err_sticky", 32'(error), 32'd1);
      send_word(32'hFAB0_FAB1);
      check("err_sync_clear", 32'(error), 32'd0);

      // N=0 no-op, then END
      send_word(32'h0100_0000);
      check("n0_err", 32'(error), 32'd0);
      check("n0_busy", 32'(busy), 32'd1);
      send_word(32'h0200_0000);
      check("end_done", 32'(done), 32'd1);
      check("end_busy", 32'(busy), 32'd0);
      idle(1);
      check("end_done_pulse", 32'(done), 32'd0);

      // Bad opcode, then a sync word landing in HEADER
      send_word(32'hFAB0_FAB1);
      send_word(32'h0700_0001);
      check("badop_err", 32'(error), 32'd1);
      send_word(32'h0100_0001);
      send_word(32'hAAAA_5555);
      check("badop_sticky", 32'(error), 32'd1);
      send_word(32'hFAB0_FAB1);
      check("badop_clear", 32'(error), 32'd0);
      send_word(32'hFAB0_FAB1);
      check("sync_as_hdr_err", 32'(error), 32'd1);
      send_word(32'hFAB0_FAB1);
      check("sync_as_hdr_clear", 32'(error), 32'd0);

      // Reset in the strobe cycle aborts the frame write
      send_word(32'h0100_0002);
      send_word(32'h5555_5555);
      reset = 1'b1;
      @(negedge UserCLK);
      check("rst_mid_strobe", 32'(FrameStrobe), 32'd0);
      @(posedge UserCLK);
      #1 reset = 1'b0;
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_data", FrameData, 32'd0);
      check("rst_mid_ready", 32'(s_ready), 32'd1);
      check("rst_mid_error", 32'(error), 32'd0);
      send_word(32'h0100_0001);
      send_word(32'h5555_5555);
      idle(1);
      check("rst_ignore_busy", 32'(busy), 32'd0);
      send_word(32'hFAB0_FAB1);
      check("rst_resync_busy", 32'(busy), 32'd1);

      // Full column with random valid gaps
      send_word(32'h0100_0014);
      strobe_cyc.delete();
      for (int i = 0; i < 20; i++) begin
         idle($urandom_range(0, 3));
         send_frame(i, $urandom());
      end
      idle(2);
      check("col_drained", 32'(sb.size()), 32'd0);
      check("col_strobe_cnt", 32'(strobe_cyc.size()), 32'd20);
      check("col_err", 32'(error), 32'd0);

`ifdef FRAME_CHECKSUM_EN
      send_word(32'h0100_0002);
      send_frame(0, 32'h0000_00FF);
      send_frame(1, 32'h0000_0F00);
      idle(1);
      send_word(32'h0000_0FFF);
      check("csum_ok_err", 32'(error), 32'd0);
      check("csum_ok_busy", 32'(busy), 32'd1);
      send_word(32'h0100_0002);
      send_frame(0, 32'h0000_00FF);
      send_frame(1, 32'h0000_0F00);
      idle(1);
      send_word(32'h0000_0000);
      check("csum_bad_err", 32'(error), 32'd1);
      send_word(32'hFAB0_FAB1);
`endif

      // Two-frame block must return straight to HEADER and accept END
      send_word(32'h0102_0002);
      send_frame(2, 32'h0000_00FF);
      send_frame(3, 32'h0000_0F00);
      idle(1);
`ifdef FRAME_CHECKSUM_EN
      send_word(32'h0000_0FFF);
`endif
      send_word(32'h0200_0000);
      check("final_done", 32'(done), 32'd1);
      check("final_err", 32'(error), 32'd0);
      idle(2);
      check("final_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
